// File: rtl/code_converter_pipe.sv
// Two-stage valid/ready pipeline converting WIDTH-bit codes between binary, Gray,
// excess-3 and pass-through, with a running count of delivered results.
module code_converter_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] conv_count
);

  localparam logic [1:0] MODE_B2G = 2'b00;
  localparam logic [1:0] MODE_G2B = 2'b01;
  localparam logic [1:0] MODE_XS3 = 2'b10;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Carry out of the +3 is intentionally dropped.
  function automatic logic [WIDTH-1:0] excess3(input logic [WIDTH-1:0] d);
    return d + WIDTH'(3);
  endfunction

  function automatic logic [WIDTH-1:0] convert(input logic [1:0] m,
                                                input logic [WIDTH-1:0] d);
    case (m)
      MODE_B2G: return bin2gray(d);
      MODE_G2B: return gray2bin(d);
      MODE_XS3: return excess3(d);
      default:  return d;
    endcase
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic [1:0]       s2_mode_q, s2_mode_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_load, s2_load, deliver;

  always_comb begin
    s2_load    = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready   = ~s1_valid_q | s2_load;
    s1_load    = in_valid & in_ready;
    deliver    = s2_valid_q & out_ready;

    s1_valid_d = s1_valid_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
    s1_mode_d  = s1_load ? in_mode : s1_mode_q;
    s1_data_d  = s1_load ? in_data : s1_data_q;

    s2_valid_d = s2_valid_q;
    if (s2_load)      s2_valid_d = 1'b1;
    else if (deliver) s2_valid_d = 1'b0;
    s2_mode_d  = s2_load ? s1_mode_q : s2_mode_q;
    s2_data_d  = s2_load ? convert(s1_mode_q, s1_data_q) : s2_data_q;

    cnt_d      = cnt_q + CNT_W'(deliver);
  end

  // Stage 1: operand capture (data needs no reset; s1_valid gates it)
  always_ff @(posedge clk) begin
    s1_mode_q <= s1_mode_d;
    s1_data_q <= s1_data_d;
  end

  // Stage 2: converted result, output registers and delivery counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= '0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_mode_q  <= s2_mode_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_mode   = s2_mode_q;
  assign conv_count = cnt_q;

endmodule

// File: tb/tb_code_converter_pipe.sv
// Scoreboard bench for code_converter_pipe: a 4-bit instance (A) and an 8-bit
// instance with a 2-bit counter (B), checked against a behavioural model.
module tb_code_converter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0] a_in_mode, a_out_mode;
  logic [3:0] a_in_data, a_out_data;
  logic [7:0] a_cnt;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0] b_in_mode, b_out_mode;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_cnt;

  code_converter_pipe #(.WIDTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode),
    .conv_count(a_cnt));

  code_converter_pipe #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
    .conv_count(b_cnt));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit rnd_rdy = 0;
  logic [33:0] qa[$];
  logic [33:0] qb[$];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: Gray code of b is b xor floor(b/2); its inverse is found by search.
  function automatic logic [31:0] model(input int w, input logic [1:0] m, input logic [31:0] d);
    logic [31:0] msk;
    msk = (32'h1 << w) - 32'h1;
    case (m)
      2'b00: return d ^ (d / 2);
      2'b01: begin
        for (int v = 0; v < (1 << w); v++)
          if (((v ^ (v / 2)) & msk) == d) return 32'(v);
        return '1;
      end
      2'b10: return (d + 3) % (32'h1 << w);
      default: return d;
    endcase
  endfunction

  // Monitors: pop-and-compare on every delivered result, hold check while stalled.
  initial begin : mon_a
    logic stall;
    logic [5:0] held;
    logic [33:0] e;
    int exp_cnt;
    stall = 0; held = '0; exp_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qa.delete(); exp_cnt = 0; stall = 0;
      end else begin
        if (stall) begin
          check("a_stall_valid", a_out_valid, 1);
          check("a_stall_hold", {a_out_mode, a_out_data}, held);
        end
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) begin
            total++;
            $display("FAIL a_unexpected_output: got mode=%0d data=%0h, expected no output", a_out_mode, a_out_data);
          end else begin
            e = qa.pop_front();
            check("a_data", a_out_data, e[31:0]);
            check("a_mode", a_out_mode, e[33:32]);
          end
          check("a_count", a_cnt, exp_cnt % 256);
          exp_cnt++;
        end
        stall = a_out_valid && !a_out_ready;
        held  = {a_out_mode, a_out_data};
      end
    end
  end

  initial begin : mon_b
    logic stall;
    logic [9:0] held;
    logic [33:0] e;
    int exp_cnt;
    stall = 0; held = '0; exp_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qb.delete(); exp_cnt = 0; stall = 0;
      end else begin
        if (stall) begin
          check("b_stall_valid", b_out_valid, 1);
          check("b_stall_hold", {b_out_mode, b_out_data}, held);
        end
        if (b_out_valid && b_out_ready) begin
          if (qb.size() == 0) begin
            total++;
            $display("FAIL b_unexpected_output: got mode=%0d data=%0h, expected no output", b_out_mode, b_out_data);
          end else begin
            e = qb.pop_front();
            check("b_data", b_out_data, e[31:0]);
            check("b_mode", b_out_mode, e[33:32]);
          end
          check("b_count", b_cnt, exp_cnt % 4);
          exp_cnt++;
        end
        stall = b_out_valid && !b_out_ready;
        held  = {b_out_mode, b_out_data};
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      a_out_ready = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_a(input logic [1:0] m, input logic [3:0] d, input logic [3:0] e);
    a_in_valid = 1; a_in_mode = m; a_in_data = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back({m, 32'(e)});
        break;
      end
      if (n > 500) begin
        $display("FAIL a_send_timeout: in_ready stuck at 0, expected 1 within 500 cycles");
        $fatal(1, "timeout");
      end
    end
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  task automatic send_b(input logic [1:0] m, input logic [7:0] d, input logic [7:0] e);
    b_in_valid = 1; b_in_mode = m; b_in_data = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back({m, 32'(e)});
        break;
      end
      if (n > 500) begin
        $display("FAIL b_send_timeout: in_ready stuck at 0, expected 1 within 500 cycles");
        $fatal(1, "timeout");
      end
    end
    @(posedge clk); #1;
    b_in_valid = 0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (qa.size() == 0 && qb.size() == 0) return;
    end
    check("drain_timeout_pending", 32'(qa.size() + qb.size()), 0);
  endtask

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    int t0, k;
    logic [1:0] m;
    logic [3:0] d4;
    rst_n = 0;
    a_in_valid = 0; a_in_mode = 0; a_in_data = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_data = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_mode", a_out_mode, 0);
    check("rst_a_count", a_cnt, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_count", b_cnt, 0);
    @(posedge clk); #1;

    // Latency: accepted at edge N, visible after edge N+1.
    send_a(2'b00, 4'b1011, 4'b1110);
    @(negedge clk);
    check("lat_after_accept_edge", a_out_valid, 0);
    @(negedge clk);
    check("lat_after_next_edge", a_out_valid, 1);
    wait_drain();

    t0 = cyc;
    for (int i = 0; i < 16; i++) send_a(2'b00, 4'(i), gray_tab[i]);
    check("b2g_stream_cycles", cyc - t0, 16);
    t0 = cyc;
    for (int i = 0; i < 16; i++) send_a(2'b01, gray_tab[i], 4'(i));
    check("g2b_stream_cycles", cyc - t0, 16);
    wait_drain();

    send_a(2'b00, 4'b1011, 4'b1110);
    send_a(2'b01, 4'b1110, 4'b1011);
    send_a(2'b10, 4'b1110, 4'b0001);
    send_a(2'b11, 4'b0110, 4'b0110);
    wait_drain();

    // Backpressure: consumer stalled for 5 cycles, producer always offering.
    a_out_ready = 0;
    k = 0;
    a_in_valid = 1; a_in_mode = 2'(k); a_in_data = 4'(k * 5 + 3);
    repeat (5) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back({a_in_mode, 32'(model(4, a_in_mode, 32'(a_in_data)))});
        k++;
      end
      @(posedge clk); #1;
      a_in_mode = 2'(k); a_in_data = 4'(k * 5 + 3);
    end
    check("bp_accepted", k, 2);
    check("bp_in_ready_low", a_in_ready, 0);
    a_in_valid = 0;
    a_out_ready = 1;
    wait_drain();
    for (int i = 0; i < 4; i++) send_a(2'(i), 4'(9 + i), 4'(model(4, 2'(i), 32'(9 + i))));
    wait_drain();

    // Reset with both stages full: held results must vanish.
    a_out_ready = 0;
    send_a(2'b00, 4'b0101, 4'b0111);
    send_a(2'b10, 4'b1111, 4'b0010);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_count", a_cnt, 0);
    check("midrst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    a_out_ready = 1;
    repeat (6) @(posedge clk);
    #1;

    // 8-bit instance: width generality and 2-bit counter wrap.
    send_b(2'b01, 8'b10000000, 8'b11111111);
    send_b(2'b10, 8'b11111110, 8'b00000001);
    send_b(2'b00, 8'h5A, 8'(model(8, 2'b00, 32'h5A)));
    send_b(2'b11, 8'hC3, 8'hC3);
    send_b(2'b10, 8'hFD, 8'h00);
    wait_drain();
    check("b_count_after_5", b_cnt, 1);

    // Randomised traffic on both instances with random consumer stalls.
    rnd_rdy = 1;
    fork
      for (int i = 0; i < 200; i++) begin
        logic [1:0] rm;
        logic [3:0] rd;
        rm = 2'($urandom_range(0, 3));
        rd = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_a(rm, rd, 4'(model(4, rm, 32'(rd))));
      end
      for (int i = 0; i < 200; i++) begin
        logic [1:0] rm;
        logic [7:0] rd;
        rm = 2'($urandom_range(0, 3));
        rd = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_b(rm, rd, 8'(model(8, rm, 32'(rd))));
      end
    join
    rnd_rdy = 0;
    a_out_ready = 1;
    b_out_ready = 1;
    wait_drain();
    m = 0; d4 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("final_a_queue_empty", qa.size(), 0);
    check("final_b_queue_empty", qb.size(), 0);
    check("final_a_out_valid", a_out_valid, {31'b0, m[0] | d4[0]});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
